// File: rtl/fpu_pkg.sv
// Shared FP32 constants and helpers for the adder-sharing arbiter.
package fpu_pkg;
  localparam int          FP32_W        = 32;
  localparam int          FPU_ADD_LAT   = 3;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam int          FP32_SIGN_BIT = 31;

  typedef logic [FP32_W-1:0] fp32_t;

  function automatic fp32_t fp32_negate(input fp32_t x);
    fp32_t r;
    r = x;
    r[FP32_SIGN_BIT] = ~x[FP32_SIGN_BIT];
    return r;
  endfunction
endpackage

// File: rtl/fpu_add_arbiter_if.sv
// Requester-side bus of fpu_add_arbiter: op issue and per-requester response slots.
// Compile-time option FPU_ARB_SUB_EN adds the req_op (subtract) lane.
interface fpu_add_arbiter_if
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][FP32_W-1:0] req_a;
  logic [N_REQ-1:0][FP32_W-1:0] req_b;
`ifdef FPU_ARB_SUB_EN
  logic [N_REQ-1:0]             req_op;
`endif
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0]             rsp_ready;
  logic [N_REQ-1:0][FP32_W-1:0] rsp_result;

`ifdef FPU_ARB_SUB_EN
  modport master (output req_valid, req_a, req_b, req_op, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result);
  modport slave  (input  req_valid, req_a, req_b, req_op, rsp_ready,
                  output req_ready, rsp_valid, rsp_result);
`else
  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_result);
`endif
endinterface

// File: rtl/fpu_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && eligible[(int'(ptr) + k) % N]) begin
        found                          = 1'b1;
        grant[(int'(ptr) + k) % N]     = 1'b1;
        idx                            = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one LAT-cycle pipelined FP32 adder among N_REQ requesters, one op in flight each.
// Compile-time option FPU_ARB_SUB_EN: req_op selects A-B by flipping B's sign on issue.
module fpu_add_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = FPU_ADD_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_add_arbiter_if.slave rq,
  output logic             fpu_valid_in,
  output fp32_t            fpu_a,
  output fp32_t            fpu_b,
  input  logic             fpu_valid_out,
  input  fp32_t            fpu_result,
  output logic             err
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]                ptr_q, ptr_d;
  logic [N_REQ-1:0]             inflight_q, inflight_d;
  logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0][FP32_W-1:0] rsp_result_q, rsp_result_d;
  logic [LAT:1]                 vld_pipe_q, vld_pipe_d;
  logic [LAT:1][IW-1:0]         idx_pipe_q, idx_pipe_d;
  logic                         err_q, err_d;

  logic [N_REQ-1:0] eligible, gnt;
  logic [IW-1:0]    gnt_idx;
  logic             wb;

  // rst_n gates eligibility so no grant leaks out combinationally during reset.
  assign eligible = rq.req_valid & ~(inflight_q | rsp_valid_q) & {N_REQ{rst_n}};

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (gnt),
    .idx      (gnt_idx)
  );

  assign rq.req_ready  = gnt;
  assign rq.rsp_valid  = rsp_valid_q;
  assign rq.rsp_result = rsp_result_q;
  assign fpu_valid_in  = |gnt;
  assign err           = err_q;
  assign wb            = fpu_valid_out & vld_pipe_q[LAT];

  always_comb begin
    fpu_a = '0;
    fpu_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fpu_a = rq.req_a[i];
        fpu_b = rq.req_b[i];
`ifdef FPU_ARB_SUB_EN
        if (rq.req_op[i]) fpu_b = fp32_negate(rq.req_b[i]);
`endif
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    inflight_d   = inflight_q;
    rsp_valid_d  = rsp_valid_q & ~rq.rsp_ready;
    rsp_result_d = rsp_result_q;
    err_d        = err_q | (fpu_valid_out ^ vld_pipe_q[LAT]);
    vld_pipe_d   = vld_pipe_q;
    idx_pipe_d   = idx_pipe_q;

    vld_pipe_d[1] = |gnt;
    idx_pipe_d[1] = gnt_idx;
    for (int s = 2; s <= LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end

    if (|gnt) begin
      ptr_d               = gnt_idx;
      inflight_d[gnt_idx] = 1'b1;
    end
    // A slot being written back is never the one being consumed: it was busy until now.
    if (wb) begin
      inflight_d[idx_pipe_q[LAT]]   = 1'b0;
      rsp_valid_d[idx_pipe_q[LAT]]  = 1'b1;
      rsp_result_d[idx_pipe_q[LAT]] = fpu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= IW'(N_REQ - 1);
      inflight_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      vld_pipe_q   <= '0;
      idx_pipe_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      vld_pipe_q   <= vld_pipe_d;
      idx_pipe_q   <= idx_pipe_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: behavioural 3-cycle FP32 adder beside the DUT, event-level reference model.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;
  import fpu_pkg::*;
  localparam int N   = 4;
  localparam int LAT = FPU_ADD_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inj = 1'b0;
  logic fpu_valid_in, fpu_valid_out, err;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fpu_add_arbiter_if #(.N_REQ(N)) bus ();

  fpu_add_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rq            (bus.slave),
    .fpu_valid_in  (fpu_valid_in),
    .fpu_a         (fpu_a),
    .fpu_b         (fpu_b),
    .fpu_valid_out (fpu_valid_out),
    .fpu_result    (fpu_result),
    .err           (err)
  );

  always #5 clk = ~clk;

  // FP32 add via IEEE double: exact widening, one rounding back to single (operands kept normal).
  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [31:0] r;
    logic [28:0] rem;
    logic a_inf, b_inf;
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if ((a[30:23] == 8'hFF && !a_inf) || (b[30:23] == 8'hFF && !b_inf)) return FP32_QNAN;
    if (a_inf && b_inf) return (a[31] != b[31]) ? FP32_QNAN : a;
    if (a_inf) return a;
    if (b_inf) return b;
    d = $realtobits(f2r(a) + f2r(b));
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    r   = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && r[0])) r[30:0] = r[30:0] + 31'd1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // Adder stand-in: fixed 3-cycle pipe; inj forces a spurious result strobe.
  logic [3:1]       add_v;
  logic [3:1][31:0] add_r;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      add_v <= '0;
      add_r <= '0;
    end else begin
      add_v <= {add_v[2:1], fpu_valid_in};
      add_r <= {add_r[2:1], fadd(fpu_a, fpu_b)};
    end
  assign fpu_valid_out = add_v[3] | inj;
  assign fpu_result    = add_r[3];

  // Reference model: per-requester pending op with due cycle, response slots, rr pointer.
  int          ptr_m;
  bit          pend [N];
  int          due  [N];
  logic [31:0] res_m[N];
  bit          sv   [N];
  logic [31:0] sr   [N];
  bit          err_m;

  task automatic model_reset();
    ptr_m = N - 1;
    err_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      sv[i]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = rnd_fp();
      bus.req_b[i] = rnd_fp();
    end
`ifdef FPU_ARB_SUB_EN
    bus.req_op = N'($urandom);
`endif
  endtask

  // One clock cycle: check DUT against the model mid-cycle, then advance the model.
  task automatic step();
    int gi;
    logic [N-1:0] g;
    logic [31:0] ea, eb;
    bit hit;
    @(negedge clk);
    gi = -1;
    g  = '0;
    ea = '0;
    eb = '0;
    for (int k = 1; k <= N; k++)
      if (gi < 0 && bus.req_valid[(ptr_m + k) % N] && !pend[(ptr_m + k) % N] && !sv[(ptr_m + k) % N])
        gi = (ptr_m + k) % N;
    if (gi >= 0) begin
      g[gi] = 1'b1;
      ea    = bus.req_a[gi];
      eb    = bus.req_b[gi];
`ifdef FPU_ARB_SUB_EN
      if (bus.req_op[gi]) eb[31] = ~eb[31];
`endif
    end
    chk("req_ready", 32'(bus.req_ready), 32'(g));
    chk("fpu_valid_in", 32'(fpu_valid_in), 32'(gi >= 0));
    chk("fpu_a", fpu_a, ea);
    chk("fpu_b", fpu_b, eb);
    chk("err", 32'(err), 32'(err_m));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid[i]), 32'(sv[i]));
      if (sv[i]) chk($sformatf("rsp_result[%0d]", i), bus.rsp_result[i], sr[i]);
    end
    hit = 1'b0;
    for (int i = 0; i < N; i++) if (bus.rsp_ready[i] && sv[i]) sv[i] = 1'b0;
    for (int i = 0; i < N; i++)
      if (pend[i] && due[i] == cyc) begin
        pend[i] = 1'b0;
        sv[i]   = 1'b1;
        sr[i]   = res_m[i];
        hit     = 1'b1;
      end
    if (inj && !hit) err_m = 1'b1;
    if (gi >= 0) begin
      pend[gi]  = 1'b1;
      due[gi]   = cyc + LAT;
      res_m[gi] = fadd(ea, eb);
      ptr_m     = gi;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    bus.req_valid    = '0;
    bus.req_valid[i] = 1'b1;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.rsp_ready    = '0;
    #1 chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << i));
    step();
    bus.req_valid = '0;
    repeat (LAT) step();
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid[i]), 32'd1);
    chk({tag, "_result"}, bus.rsp_result[i], exp);
    bus.rsp_ready[i] = 1'b1;
    step();
    bus.rsp_ready = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fpu_valid_in"}, 32'(fpu_valid_in), 32'd0);
    chk({tag, "_fpu_a"}, fpu_a, 32'd0);
    chk({tag, "_fpu_b"}, fpu_b, 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("%s_rsp_result[%0d]", tag, i), bus.rsp_result[i], 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
`ifdef FPU_ARB_SUB_EN
    bus.req_op    = '0;
`endif
    model_reset();
    // Requests raised during reset must not be granted.
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    bus.req_valid = '0;
    rst_n = 1'b1;

    // 1+2 on req0; then a single op on req3 leaves the pointer at 3.
    one_op("t1", 0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    one_op("ptr3", 3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

    // All four valid from ptr=3: grants 0,1,2,3 on consecutive cycles.
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    rand_ops();
    for (int c = 0; c < N; c++) begin
      #1 chk("t2_grant_order", 32'(bus.req_ready), 32'(1 << c));
      step();
      rand_ops();
    end
    repeat (8) begin step(); rand_ops(); end

    // Back-pressure on slot 1.
    bus.rsp_ready = 4'b1101;
    repeat (14) begin step(); rand_ops(); end
    chk("t3_rsp_valid1_held", 32'(bus.rsp_valid[1]), 32'd1);
    bus.rsp_ready = '1;

    // Random traffic.
    repeat (300) begin
      bus.req_valid = N'($urandom);
      bus.rsp_ready = N'($urandom);
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (8) step();

    // Special values.
    one_op("t4_inf", 2, 32'h7F80_0000, 32'hFF80_0000, FP32_QNAN);
`ifdef FPU_ARB_SUB_EN
    bus.req_op[1] = 1'b1;
    one_op("t4_sub", 1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    bus.req_op = '0;
`endif

    // Spurious adder strobe with an empty tag pipe.
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Reset two cycles after a grant.
    bus.req_valid = 4'b0100;
    rand_ops();
    step();
    bus.req_valid = '0;
    repeat (2) step();
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1 chk_all_zero("t5_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    repeat (6) step();
    bus.req_valid = '1;
    rand_ops();
    #1 chk("t5_first_grant", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
